// File: rtl/pipeline_one_drain.sv
// Four-direction hold-and-drain pipeline stage.
// Captures N/S/E/W words on a strobe, then presents each valid code in turn.
module pipeline_one_drain (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] noun,
    input  logic [9:0] soun,
    input  logic [9:0] eoun,
    input  logic [9:0] woun,
    input  logic       clksig,
    input  logic       rdy,
    output logic [6:0] inc,
    output logic       nsig,
    output logic       ssig,
    output logic       esig,
    output logic       wsig,
    output logic [1:0] tag,
    output logic       busy,
    output logic       done,
    output logic [2:0] sent_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        FIN  = 2'd2
    } state_t;

    localparam logic [1:0] PN = 2'd0;
    localparam logic [1:0] PS = 2'd1;
    localparam logic [1:0] PE = 2'd2;
    localparam logic [1:0] PW = 2'd3;

    state_t     state;
    logic [9:0] hn;
    logic [9:0] hs;
    logic [9:0] he;
    logic [9:0] hw;
    logic [1:0] ptr;
    logic [9:0] cur;
    logic       live;

    // Select the held word under the scan pointer.
    always_comb begin
        cur = hn;
        unique case (ptr)
            PN: cur = hn;
            PS: cur = hs;
            PE: cur = he;
            PW: cur = hw;
        endcase
    end

    // A strobe is live only while draining a valid word.
    assign live = (state == SEND) && cur[9];

    assign inc  = live ? cur[6:0] : 7'd0;
    assign tag  = live ? cur[8:7] : 2'd0;
    assign nsig = live && (ptr == PN);
    assign ssig = live && (ptr == PS);
    assign esig = live && (ptr == PE);
    assign wsig = live && (ptr == PW);
    assign busy = (state != IDLE);
    assign done = (state == FIN);

    // Drain FSM: load on strobe, scan N..W, stall on a presented word until rdy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            hn       <= '0;
            hs       <= '0;
            he       <= '0;
            hw       <= '0;
            ptr      <= PN;
            sent_cnt <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (clksig) begin
                        hn       <= noun;
                        hs       <= soun;
                        he       <= eoun;
                        hw       <= woun;
                        ptr      <= PN;
                        sent_cnt <= '0;
                        state    <= SEND;
                    end
                end
                SEND: begin
                    if (!cur[9] || rdy) begin
                        if (cur[9]) begin
                            sent_cnt <= sent_cnt + 3'd1;
                        end
                        if (ptr == PW) begin
                            state <= FIN;
                        end else begin
                            ptr <= ptr + 2'd1;
                        end
                    end
                end
                FIN: begin
                    ptr   <= PN;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
